key_schedule_feeder: RTL

- Upstream stage of the time-keyed locked FSMs; drives their keyinput0..N bus.
- Accepts NUM_KEYS keys over a serial load handshake and stores them.
- Presents each stored key for PHASE_LEN falling edges, in a fixed rotation.
- Runs a phase counter that mirrors the locked FSM's internal counter, so the correct key is stable at every consumer sampling edge.

---
 rtl/key_schedule_feeder_if.sv | 44 ++++
 rtl/key_schedule_feeder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/key_schedule_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : key_schedule_feeder_if
// Brief   : Load handshake and key bus between the key source and the feeder.
//           KEY_PARITY_EN adds the sticky parity_err flag.
// Revision: 1.0
// ============================================================================
interface key_schedule_feeder_if #(
  parameter int KEY_W     = 6,
  parameter int NUM_KEYS  = 2,
  parameter int PHASE_LEN = 4
);
  localparam int c_PH = NUM_KEYS * PHASE_LEN;
  localparam int c_PW = (c_PH > 1) ? $clog2(c_PH) : 1;

  logic             load_start;
  logic             load_valid;
  logic             load_bit;
  logic             load_ready;
  logic             clear;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [c_PW-1:0]  phase;
`ifdef KEY_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output load_start, load_valid, load_bit, clear,
    input  load_ready, key_out, key_valid, phase
`ifdef KEY_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  load_start, load_valid, load_bit, clear,
    output load_ready, key_out, key_valid, phase
`ifdef KEY_PARITY_EN
    , output parity_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/key_schedule_feeder.sv
`default_nettype none
// ============================================================================
// Module  : key_schedule_feeder
// Brief   : Serially loads NUM_KEYS keys and rotates them onto the consumer
//           key bus in lockstep with a mirrored phase counter (falling edge).
//           Optional: KEY_PARITY_EN appends an even-parity check to the load.
// Revision: 1.0
// ============================================================================
module key_schedule_feeder #(
  parameter int KEY_W     = 6,
  parameter int NUM_KEYS  = 2,
  parameter int PHASE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  key_schedule_feeder_if.slave bus
);
  localparam int c_W  = NUM_KEYS * KEY_W;
  localparam int c_PH = NUM_KEYS * PHASE_LEN;
  localparam int c_PW = (c_PH > 1) ? $clog2(c_PH) : 1;
  localparam int c_SW = c_PW + 1;
`ifdef KEY_PARITY_EN
  localparam int c_BITS = c_W + 1;
`else
  localparam int c_BITS = c_W;
`endif
  localparam int c_CW = $clog2(c_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [c_W-1:0]  r_sr, w_sr_next;
  logic [c_CW-1:0] r_cnt, w_cnt_next;
  logic [c_PW-1:0] r_phase, w_phase_next;
  logic [c_SW-1:0] w_slot;
  logic [KEY_W-1:0] w_key_sel;
`ifdef KEY_PARITY_EN
  logic            r_perr, w_perr_next;
  logic            w_par_ok;
  assign w_par_ok = ~(^r_sr ^ bus.load_bit);
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
`ifdef KEY_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_phase <= w_phase_next;
`ifdef KEY_PARITY_EN
      r_perr  <= w_perr_next;
`endif
    end
  end

  // Phase runs regardless of load/clear so it stays aligned with the consumer.
  assign w_phase_next = (r_phase == c_PW'(c_PH - 1)) ? '0 : r_phase + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
`ifdef KEY_PARITY_EN
    w_perr_next  = r_perr;
`endif
    if (bus.clear) begin
      w_sr_next    = '0;
      w_state_next = S_IDLE;
    end else if (bus.load_start) begin
      w_state_next = S_LOAD;
      w_cnt_next   = '0;
`ifdef KEY_PARITY_EN
      w_perr_next  = 1'b0;
`endif
    end else if (r_state == S_LOAD && bus.load_valid) begin
`ifdef KEY_PARITY_EN
      if (r_cnt == c_CW'(c_W)) begin
        if (w_par_ok) begin
          w_state_next = S_ARMED;
        end else begin
          w_sr_next    = '0;
          w_state_next = S_IDLE;
          w_perr_next  = 1'b1;
        end
      end else begin
        w_sr_next  = {bus.load_bit, r_sr[c_W-1:1]};
        w_cnt_next = r_cnt + 1'b1;
      end
`else
      w_sr_next  = {bus.load_bit, r_sr[c_W-1:1]};
      w_cnt_next = r_cnt + 1'b1;
      if (r_cnt == c_CW'(c_W - 1)) begin
        w_state_next = S_ARMED;
      end
`endif
    end
  end

  // Widened by one bit so PHASE_LEN never truncates in the divisor.
  assign w_slot = c_SW'(r_phase) / c_SW'(PHASE_LEN);

  always_comb begin
    w_key_sel = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_slot == c_SW'(k)) begin
        w_key_sel = r_sr[k*KEY_W +: KEY_W];
      end
    end
  end

  assign bus.key_out    = (r_state == S_ARMED) ? w_key_sel : '0;
  assign bus.key_valid  = (r_state == S_ARMED);
  assign bus.load_ready = (r_state == S_LOAD);
  assign bus.phase      = r_phase;
`ifdef KEY_PARITY_EN
  assign bus.parity_err = r_perr;
`endif

endmodule
`default_nettype wire
